// File: rtl/x74169_pkg.sv
// x74169_pkg: constants and helpers shared by the x74169 up/down counter
// and its 4-bit slice. Direction encoding and slice width match x74161.
package x74169_pkg;

   localparam logic DIR_UP  = 1'b1;
   localparam logic DIR_DN  = 1'b0;
   localparam int   SLICE_W = 4;

   // True when a slice sits at the terminal value for the given direction:
   // all-ones when counting up, zero when counting down.
   function automatic logic at_term(input logic [SLICE_W-1:0] q, input logic ud);
      logic r;
      if (ud == DIR_UP) r = &q;
      else              r = ~|q;
      return r;
   endfunction

endpackage

// File: rtl/x74169_slice.sv
// x74169_slice: 4-bit presettable up/down counter slice.
// Optional feature macro: X74169_SAT_EN adds the SAT input, which freezes
// counting while the complete cascaded counter sits at its terminal value.
module x74169_slice
   import x74169_pkg::*;
(
   input  logic               CP,
   input  logic               CR,
   input  logic               PE,
   input  logic               CEP,
   input  logic               CET,
   input  logic               U_D,
`ifdef X74169_SAT_EN
   input  logic               SAT,
`endif
   input  logic [SLICE_W-1:0] D,
   output logic [SLICE_W-1:0] Q,
   output logic               TC
);

   logic [SLICE_W-1:0] q_r;
   logic [SLICE_W-1:0] q_nxt_s;
   logic               cnt_en_s;

   // Saturation is decided for the whole chain, not per slice, so lower
   // slices still carry normally while the full counter is below terminal.
`ifdef X74169_SAT_EN
   assign cnt_en_s = CEP & CET & ~SAT;
`else
   assign cnt_en_s = CEP & CET;
`endif

   // Next state: load beats count, count beats hold.
   always_comb begin
      q_nxt_s = q_r;
      if (!PE) begin
         q_nxt_s = D;
      end else if (cnt_en_s) begin
         if (U_D == DIR_UP) q_nxt_s = q_r + 4'd1;
         else               q_nxt_s = q_r - 4'd1;
      end else begin
         q_nxt_s = q_r;
      end
   end

   // State register with asynchronous active-low clear.
   always_ff @(posedge CP or negedge CR) begin
      if (!CR) q_r <= '0;
      else     q_r <= q_nxt_s;
   end

   assign Q  = q_r;
   assign TC = CET & at_term(q_r, U_D);

endmodule

// File: rtl/x74169.sv
// x74169: WIDTH-bit presettable binary up/down counter built from 4-bit
// slices chained TC -> CET, so the top TC ripples through every slice.
// Optional feature macro: X74169_SAT_EN (saturate at the terminal value
// instead of wrapping). WIDTH must be a multiple of 4.
module x74169
   import x74169_pkg::*;
#(
   parameter int WIDTH = 4
) (
   input  logic             CP,
   input  logic             CR,
   input  logic             PE,
   input  logic             CEP,
   input  logic             CET,
   input  logic             U_D,
   input  logic [WIDTH-1:0] D,
   output logic [WIDTH-1:0] Q,
   output logic             TC
);

   localparam int NS = WIDTH / SLICE_W;

   // tc_chain_s[i] is the trickle enable into slice i; the last entry is TC.
   logic [NS:0] tc_chain_s;

   assign tc_chain_s[0] = CET;

   for (genvar i = 0; i < NS; i++) begin : g_slice
      x74169_slice u_slice (
         .CP  (CP),
         .CR  (CR),
         .PE  (PE),
         .CEP (CEP),
         .CET (tc_chain_s[i]),
         .U_D (U_D),
`ifdef X74169_SAT_EN
         .SAT (tc_chain_s[NS]),
`endif
         .D   (D[i*SLICE_W +: SLICE_W]),
         .Q   (Q[i*SLICE_W +: SLICE_W]),
         .TC  (tc_chain_s[i+1])
      );
   end

   assign TC = tc_chain_s[NS];

endmodule

// File: tb/tb_x74169.sv
// tb_x74169: directed bench for x74169 at WIDTH=4 and WIDTH=8. Expected
// values are pushed to a scoreboard queue as stimulus is applied and are
// popped and compared once the DUT output is due.
module tb_x74169;

   typedef struct {
      string      tag;
      logic [7:0] q;
      logic       tc;
      bit         wide;
   } exp_t;

   exp_t sbq[$];
   int   total  = 0;
   int   passed = 0;

   logic       CP = 1'b0;
   logic       a_cr, a_pe, a_cep, a_cet, a_ud;
   logic [3:0] a_d, a_q;
   logic       a_tc;
   logic       b_cr, b_pe, b_cep, b_cet, b_ud;
   logic [7:0] b_d, b_q;
   logic       b_tc;

   always #5 CP = ~CP;

   x74169 #(.WIDTH(4)) dut_a (
      .CP(CP), .CR(a_cr), .PE(a_pe), .CEP(a_cep), .CET(a_cet),
      .U_D(a_ud), .D(a_d), .Q(a_q), .TC(a_tc)
   );

   x74169 #(.WIDTH(8)) dut_b (
      .CP(CP), .CR(b_cr), .PE(b_pe), .CEP(b_cep), .CET(b_cet),
      .U_D(b_ud), .D(b_d), .Q(b_q), .TC(b_tc)
   );

   task automatic push(input string tag, input logic [7:0] q, input logic tc, input bit wide);
      exp_t e;
      e.tag  = tag;
      e.q    = q;
      e.tc   = tc;
      e.wide = wide;
      sbq.push_back(e);
   endtask

   task automatic check();
      exp_t       e;
      logic [7:0] oq;
      logic       otc;
      e   = sbq.pop_front();
      oq  = e.wide ? b_q : {4'h0, a_q};
      otc = e.wide ? b_tc : a_tc;
      total = total + 1;
      assert (oq === e.q) passed = passed + 1;
      else $error("FAIL %s Q observed=%h expected=%h", e.tag, oq, e.q);
      total = total + 1;
      assert (otc === e.tc) passed = passed + 1;
      else $error("FAIL %s TC observed=%b expected=%b", e.tag, otc, e.tc);
   endtask

   // Advance one rising edge and sample 1 time unit after it.
   task automatic tick();
      @(posedge CP);
      #1;
   endtask

   initial begin
      // Clear applied before any edge.
      a_cr = 1'b0; a_pe = 1'b1; a_cep = 1'b0; a_cet = 1'b1; a_ud = 1'b0; a_d = 4'b1100;
      b_cr = 1'b0; b_pe = 1'b1; b_cep = 1'b0; b_cet = 1'b1; b_ud = 1'b0; b_d = 8'h00;
      #2;
      push("clr_dn", 8'h00, 1'b1, 1'b0); check();
      push("clr_b",  8'h00, 1'b1, 1'b1); check();
      a_ud = 1'b1;
      #1;
      push("clr_up", 8'h00, 1'b0, 1'b0); check();

      // Load 0011 then count down through zero.
      a_cr = 1'b1; a_pe = 1'b0; a_d = 4'b0011; a_ud = 1'b0;
      push("ld3", 8'h03, 1'b0, 1'b0); tick(); check();
      a_pe = 1'b1; a_cep = 1'b1; a_cet = 1'b1;
      push("dn2", 8'h02, 1'b0, 1'b0); tick(); check();
      push("dn1", 8'h01, 1'b0, 1'b0); tick(); check();
      push("dn0", 8'h00, 1'b1, 1'b0); tick(); check();
`ifdef X74169_SAT_EN
      push("dn_sat", 8'h00, 1'b1, 1'b0); tick(); check();
`else
      push("dn_wrap", 8'h0F, 1'b0, 1'b0); tick(); check();
`endif

      // Load 1110 then count up across the top.
      a_pe = 1'b0; a_d = 4'b1110; a_ud = 1'b1;
      push("ldE", 8'h0E, 1'b0, 1'b0); tick(); check();
      a_pe = 1'b1;
      push("upF", 8'h0F, 1'b1, 1'b0); tick(); check();
`ifdef X74169_SAT_EN
      push("up_sat1", 8'h0F, 1'b1, 1'b0); tick(); check();
      push("up_sat2", 8'h0F, 1'b1, 1'b0); tick(); check();
`else
      push("up_wrap0", 8'h00, 1'b0, 1'b0); tick(); check();
      push("up_wrap1", 8'h01, 1'b0, 1'b0); tick(); check();
`endif

      // Enables and priority.
      a_pe = 1'b0; a_d = 4'b0101;
      push("ld5", 8'h05, 1'b0, 1'b0); tick(); check();
      a_pe = 1'b1; a_cep = 1'b0; a_cet = 1'b1;
      push("hold_cep", 8'h05, 1'b0, 1'b0); tick(); check();
      a_cep = 1'b1; a_cet = 1'b0;
      push("hold_cet", 8'h05, 1'b0, 1'b0); tick(); check();
      a_pe = 1'b0; a_cet = 1'b1; a_d = 4'b1010;
      push("ld_wins", 8'h0A, 1'b0, 1'b0); tick(); check();
      a_d = 4'b0000;
      push("ld0", 8'h00, 1'b0, 1'b0); tick(); check();
      a_pe = 1'b1; a_cep = 1'b0; a_cet = 1'b0; a_ud = 1'b0;
      #1;
      push("tc_cet0", 8'h00, 1'b0, 1'b0); check();
      a_cet = 1'b1;
      #1;
      push("tc_cet1", 8'h00, 1'b1, 1'b0); check();

      // Async clear mid-count: count 0110 -> 0111, pulse CR between edges.
      a_pe = 1'b0; a_d = 4'b0110; a_ud = 1'b1;
      push("ld6", 8'h06, 1'b0, 1'b0); tick(); check();
      a_pe = 1'b1; a_cep = 1'b1; a_cet = 1'b1;
      push("up7", 8'h07, 1'b0, 1'b0); tick(); check();
      #1 a_cr = 1'b0;
      #1;
      push("async_clr", 8'h00, 1'b0, 1'b0); check();
      a_cr = 1'b1;
      push("resume", 8'h01, 1'b0, 1'b0); tick(); check();

      // 8-bit cascade.
      b_cr = 1'b1; b_pe = 1'b0; b_d = 8'h01; b_ud = 1'b0;
      push("b_ld01", 8'h01, 1'b0, 1'b1); tick(); check();
      b_pe = 1'b1; b_cep = 1'b1; b_cet = 1'b1;
      push("b_dn00", 8'h00, 1'b1, 1'b1); tick(); check();
`ifdef X74169_SAT_EN
      push("b_dn_sat", 8'h00, 1'b1, 1'b1); tick(); check();
`else
      push("b_dnFF", 8'hFF, 1'b0, 1'b1); tick(); check();
`endif
      b_pe = 1'b0; b_d = 8'h0F; b_ud = 1'b1;
      push("b_ld0F", 8'h0F, 1'b0, 1'b1); tick(); check();
      b_pe = 1'b1;
      push("b_carry", 8'h10, 1'b0, 1'b1); tick(); check();
      b_pe = 1'b0; b_d = 8'hFF; b_cep = 1'b0;
      push("b_ldFF", 8'hFF, 1'b1, 1'b1); tick(); check();
      b_pe = 1'b1; b_cep = 1'b1;
`ifdef X74169_SAT_EN
      push("b_up_sat", 8'hFF, 1'b1, 1'b1); tick(); check();
`else
      push("b_up_wrap", 8'h00, 1'b0, 1'b1); tick(); check();
`endif

      total = total + 1;
      assert (sbq.size() === 0) passed = passed + 1;
      else $error("FAIL sb_empty observed=%0d expected=0", sbq.size());

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
